// File: rtl/matrix_addsub_stream.sv
// matrix_addsub_stream: streams ROWSxCOLS matrices LANES elements per beat, emitting A+B or A-B per row,
// with optional saturation and a 2-deep ready/valid output FIFO behind a single stage-1 register.
module matrix_addsub_stream #(
    parameter int IN_WIDTH = 10,
    parameter int ROWS = 10,
    parameter int COLS = 12,
    parameter int LANES = 4,
    parameter int SATURATE = 0,
    localparam int BEATS = COLS / LANES,
    localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1,
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1,
    localparam int OW = IN_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   clearFlags,
    input  logic                   inReady,
    input  logic                   sub,
    input  logic [LANES*IN_WIDTH-1:0] A,
    input  logic [LANES*IN_WIDTH-1:0] B,
    output logic                   readyForNewVectorStart,
    output logic [CW-1:0]          vectorInSeries,
    output logic [RW-1:0]          vectorSetInNo,
    output logic [LANES*OW-1:0]    S,
    output logic                   outReady,
    input  logic                   outAccept,
    output logic [CW-1:0]          vectorOutSeries,
    output logic [RW-1:0]          vectorSetOutNo,
    output logic                   matrixDone,
    output logic                   satFlag
);
    logic rowSub, subEff, s1Valid, accept, pop, move;
    logic lastInCol, lastInRow, lastOutCol, lastOutRow;
    logic [1:0] fifoCount;
    logic [LANES-1:0] clamp;
    logic [LANES*OW-1:0] res, s1Data, f0, f1;

    // The first beat of a row uses the live sub input; later beats use the value latched with it.
    assign subEff = (vectorInSeries == '0) ? sub : rowSub;
    assign readyForNewVectorStart = enable && !reset && !(s1Valid && fifoCount == 2'd2);
    assign accept = enable && inReady && readyForNewVectorStart;
    assign outReady = fifoCount != 2'd0;
    assign pop = enable && outReady && outAccept;
    assign move = s1Valid && (fifoCount != 2'd2 || pop);
    assign S = f0;
    assign lastInCol = vectorInSeries == CW'(BEATS - 1);
    assign lastInRow = vectorSetInNo == RW'(ROWS - 1);
    assign lastOutCol = vectorOutSeries == CW'(BEATS - 1);
    assign lastOutRow = vectorSetOutNo == RW'(ROWS - 1);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [OW-1:0] a, b, full;
        assign a = {A[k*IN_WIDTH+IN_WIDTH-1], A[k*IN_WIDTH +: IN_WIDTH]};
        assign b = {B[k*IN_WIDTH+IN_WIDTH-1], B[k*IN_WIDTH +: IN_WIDTH]};
        assign full = subEff ? a - b : a + b;
        // Overflow of the IN_WIDTH range shows as the top two bits disagreeing.
        assign clamp[k] = SATURATE != 0 && full[OW-1] != full[OW-2];
        assign res[k*OW +: OW] = clamp[k] ? {full[OW-1], full[OW-1], {(IN_WIDTH-1){~full[OW-1]}}} : full;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vectorInSeries <= '0;
            vectorSetInNo <= '0;
            vectorOutSeries <= '0;
            vectorSetOutNo <= '0;
            rowSub <= 1'b0;
            s1Valid <= 1'b0;
            s1Data <= '0;
            f0 <= '0;
            f1 <= '0;
            fifoCount <= 2'd0;
            matrixDone <= 1'b0;
            satFlag <= 1'b0;
        end else begin
            matrixDone <= pop && lastOutCol && lastOutRow;
            if (enable) begin
                if (accept) begin
                    vectorInSeries <= lastInCol ? '0 : vectorInSeries + 1'b1;
                    if (lastInCol) vectorSetInNo <= lastInRow ? '0 : vectorSetInNo + 1'b1;
                    if (vectorInSeries == '0) rowSub <= sub;
                    s1Data <= res;
                end
                if (pop) begin
                    vectorOutSeries <= lastOutCol ? '0 : vectorOutSeries + 1'b1;
                    if (lastOutCol) vectorSetOutNo <= lastOutRow ? '0 : vectorSetOutNo + 1'b1;
                end
                s1Valid <= accept || (s1Valid && !move);
                if (pop && fifoCount == 2'd2) f0 <= f1;
                else if (move && fifoCount == (pop ? 2'd1 : 2'd0)) f0 <= s1Data;
                if (move && fifoCount == (pop ? 2'd2 : 2'd1)) f1 <= s1Data;
                fifoCount <= fifoCount + 2'(move) - 2'(pop);
                satFlag <= (accept && |clamp) || (satFlag && !clearFlags);
            end
        end
    end
endmodule

// File: tb/tb_matrix_addsub_stream.sv
// tb_matrix_addsub_stream: directed table-driven bench; runs a full-precision and a saturating instance
// side by side on the same stimulus and checks every popped beat against hand-computed values.
module tb_matrix_addsub_stream;
    localparam int W = 10, L = 4, OW = 11;

    logic clk = 1'b0, reset, enable, clearFlags, inReady, sub, outAccept;
    logic [L*W-1:0] A, B;
    logic rdy0, outReady0, done0, sat0, rdy1, outReady1, done1, sat1;
    logic [1:0] vis0, vos0, vis1, vos1;
    logic [3:0] vsi0, vso0, vsi1, vso1;
    logic [L*OW-1:0] S0, S1, curE0, curE1;

    always #5 clk = ~clk;

    matrix_addsub_stream #(.SATURATE(0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .clearFlags(clearFlags), .inReady(inReady),
        .sub(sub), .A(A), .B(B), .readyForNewVectorStart(rdy0), .vectorInSeries(vis0),
        .vectorSetInNo(vsi0), .S(S0), .outReady(outReady0), .outAccept(outAccept),
        .vectorOutSeries(vos0), .vectorSetOutNo(vso0), .matrixDone(done0), .satFlag(sat0));

    matrix_addsub_stream #(.SATURATE(1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .clearFlags(clearFlags), .inReady(inReady),
        .sub(sub), .A(A), .B(B), .readyForNewVectorStart(rdy1), .vectorInSeries(vis1),
        .vectorSetInNo(vsi1), .S(S1), .outReady(outReady1), .outAccept(outAccept),
        .vectorOutSeries(vos1), .vectorSetOutNo(vso1), .matrixDone(done1), .satFlag(sat1));

    typedef struct { int a; int b; logic sb; int e0; int e1; } vec_t;
    typedef struct packed { logic [L*OW-1:0] e0; logic [L*OW-1:0] e1; } exp_t;
    vec_t tbl [30];
    exp_t expQ [$];
    int nChecks = 0, nFails = 0;
    int inN = 0, outN = 0, doneCnt = 0, popCnt = 0, cyc = 0;
    int firstOut = -1, accFirst = -1, accLast = -1, lastPopRow = -1, lastPopCol = -1;

    function automatic logic [L*W-1:0] repA(input int v);
        return {L{W'(v)}};
    endfunction

    function automatic logic [L*OW-1:0] repS(input int v);
        return {L{OW'(v)}};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference tag counters and the expected-beat queue, advanced from the handshake signals.
    always @(negedge clk) begin
        if (reset) begin
            expQ.delete();
            inN = 0;
            outN = 0;
        end else begin
            chk("in_tags0", {vsi0, vis0}, {4'((inN / 3) % 10), 2'(inN % 3)});
            chk("in_tags1", {vsi1, vis1}, {4'((inN / 3) % 10), 2'(inN % 3)});
            chk("out_tags0", {vso0, vos0}, {4'((outN / 3) % 10), 2'(outN % 3)});
            chk("out_tags1", {vso1, vos1}, {4'((outN / 3) % 10), 2'(outN % 3)});
            if (done0) begin
                doneCnt++;
                chk("done_tags", {4'(lastPopRow), 2'(lastPopCol)}, {4'd9, 2'd2});
            end
            if (outReady0) begin
                if (firstOut < 0) firstOut = cyc;
                if (expQ.size() == 0) chk("spurious_out", expQ.size(), 1);
                else begin
                    chk("S_full", S0, expQ[0].e0);
                    chk("S_sat", S1, expQ[0].e1);
                end
                if (enable && outAccept) begin
                    if (expQ.size() != 0) void'(expQ.pop_front());
                    lastPopRow = (outN / 3) % 10;
                    lastPopCol = outN % 3;
                    outN++;
                    popCnt++;
                end
            end
            if (enable && inReady && rdy0) begin
                expQ.push_back('{curE0, curE1});
                if (accFirst < 0) accFirst = cyc;
                if (inN == 29 && accLast < 0) accLast = cyc;
                inN++;
            end
        end
    end

    task automatic send();
        int t = 0;
        @(negedge clk);
        while (!(enable && inReady && rdy0)) begin
            t++;
            if (t > 20) begin
                chk("accept_timeout", t, 0);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #2 inReady = 1'b0;
    endtask

    task automatic beat(input int a, input int b, input logic sb, input int e0, input int e1);
        A = repA(a);
        B = repA(b);
        sub = sb;
        curE0 = repS(e0);
        curE1 = repS(e1);
        inReady = 1'b1;
        send();
    endtask

    task automatic drain();
        int t = 0;
        while (expQ.size() != 0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("drain", expQ.size(), 0);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        reset = 1'b1; enable = 1'b1; clearFlags = 1'b0; inReady = 1'b0; sub = 1'b0;
        outAccept = 1'b1; A = '0; B = '0; curE0 = '0; curE1 = '0;
        for (int i = 0; i < 30; i++) tbl[i] = '{100, 23, 1'b0, 123, 123};
        tbl[0] = '{-512, 511, 1'b1, -1023, -512};
        tbl[1] = '{-512, 511, 1'b0, -1023, -512};
        tbl[2] = '{-512, 511, 1'b0, -1023, -512};
        tbl[3] = '{-512, 511, 1'b0, -1, -1};
        tbl[4] = '{-512, 511, 1'b0, -1, -1};
        tbl[5] = '{-512, 511, 1'b0, -1, -1};
        tbl[6] = '{500, 100, 1'b0, 600, 511};
        tbl[7] = '{511, 511, 1'b0, 1022, 511};
        tbl[8] = '{-512, -512, 1'b1, -1024, -512};
        tbl[9] = '{-500, 100, 1'b1, -600, -512};
        tbl[10] = '{511, -512, 1'b0, 1023, 511};
        tbl[11] = '{7, 9, 1'b0, -2, -2};
        tbl[15] = '{100, 23, 1'b1, 77, 77};
        tbl[16] = '{100, 23, 1'b0, 77, 77};
        tbl[17] = '{100, 23, 1'b0, 77, 77};
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ready", {rdy0, rdy1}, 2'b00);
        chk("rst_outReady", {outReady0, outReady1}, 2'b00);
        chk("rst_S0", S0, 0);
        chk("rst_S1", S1, 0);
        chk("rst_flags", {done0, sat0, done1, sat1}, 4'b0000);
        chk("rst_tags", {vsi0, vis0, vso0, vos0}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_release", rdy0, 1);
        @(posedge clk);
        #2;

        for (int i = 0; i < 30; i++) beat(tbl[i].a, tbl[i].b, tbl[i].sb, tbl[i].e0, tbl[i].e1);
        drain();
        chk("latency", firstOut - accFirst, 2);
        chk("throughput", accLast - accFirst, 29);
        chk("matrix_done_count", doneCnt, 1);
        chk("pop_count", popCnt, 30);
        chk("satflag_sat", sat1, 1);
        chk("satflag_full", sat0, 0);

        outAccept = 1'b0;
        acc = 0;
        for (int j = 1; j <= 6; j++) begin
            A = repA(10 * j);
            B = repA(j);
            sub = 1'b0;
            curE0 = repS(11 * j);
            curE1 = repS(11 * j);
            inReady = 1'b1;
            @(negedge clk);
            if (enable && rdy0) acc++;
            @(posedge clk);
            #2;
        end
        inReady = 1'b0;
        chk("bp_accepts", acc, 3);
        chk("bp_ready_low", rdy0, 0);
        outAccept = 1'b1;
        @(negedge clk);
        chk("bp_ready_before_pop", rdy0, 0);
        @(negedge clk);
        chk("bp_ready_back", rdy0, 1);
        @(posedge clk);
        #2;
        drain();

        clearFlags = 1'b1;
        @(posedge clk);
        #2 clearFlags = 1'b0;
        chk("sat_cleared", sat1, 0);
        clearFlags = 1'b1;
        beat(500, 100, 1'b0, 600, 511);
        clearFlags = 1'b0;
        chk("sat_set_beats_clear", sat1, 1);
        beat(0, 0, 1'b1, 0, 0);
        beat(-500, 100, 1'b0, -400, -400);
        clearFlags = 1'b1;
        @(posedge clk);
        #2 clearFlags = 1'b0;
        chk("sat_cleared_again", sat1, 0);
        chk("satflag_full_never", sat0, 0);
        drain();

        for (int j = 0; j < 7; j++) begin
            beat(10 * j, j, 1'b0, 11 * j, 11 * j);
            if (j == 3) begin
                enable = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_outReady", outReady0, 1);
                    chk("stall_ready", rdy0, 0);
                    @(posedge clk);
                    #2;
                end
                enable = 1'b1;
            end
        end
        chk("pre_reset_row", vsi0, 4);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_outReady", {outReady0, outReady1}, 2'b00);
        chk("async_rst_S", {S0, S1}, 0);
        chk("async_rst_tags", {vsi0, vis0, vso0, vos0}, 0);
        chk("async_rst_ready", rdy0, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        beat(5, 3, 1'b1, 2, 2);
        A = {10'd40, 10'd30, 10'd20, 10'd10};
        B = {10'd4, 10'd3, 10'd2, 10'd1};
        sub = 1'b0;
        curE0 = {11'd36, 11'd27, 11'd18, 11'd9};
        curE1 = {11'd36, 11'd27, 11'd18, 11'd9};
        inReady = 1'b1;
        send();
        drain();
        chk("post_reset_out_tags", {vso0, vos0}, {4'd0, 2'd2});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
        $finish;
    end
endmodule
